// File: rtl/unary_pkg.sv
// Shared types for the unary accumulator/emitter: FSM state encoding and popcount width helper.
package unary_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  // Bits needed to hold a popcount of n inputs (0..n).
  function automatic int unsigned pc_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational popcount of NUM_IN unary input bits.
module unary_popcount
  import unary_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned PC_W = pc_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] din,
  output logic [PC_W-1:0]   pc
);

  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      pc = pc + PC_W'(din[i]);
    end
  end

endmodule

// File: rtl/unary_add_n.sv
// Multi-channel unary accumulator/emitter: accumulates input popcounts, then drains the count as a unary stream.
// Optional build macro UNARY_ADD_SAT_EN: saturate the counter at MAX instead of wrapping.
module unary_add_n
  import unary_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned CNT_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              read_or_write,
  input  logic [NUM_IN-1:0] din,
  output logic              dout,
  output logic              C,
  output logic              ovf,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  count_q
);

  localparam int unsigned PC_W  = pc_width(NUM_IN);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] MAX = {1'b0, {CNT_W{1'b1}}};

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic             over;

  unary_popcount #(.NUM_IN(NUM_IN)) u_popcount (
    .din (din),
    .pc  (pc)
  );

  assign sum  = {1'b0, count_q} + SUM_W'(pc);
  assign over = (sum > MAX);
  assign busy = (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count_q <= '0;
      dout    <= 1'b0;
      C       <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else if (!en) begin
      done <= 1'b0;
    end else if (!read_or_write) begin
      state <= S_READ;
      C     <= over;
      ovf   <= ovf | over;
      dout  <= 1'b0;
      done  <= 1'b0;
`ifdef UNARY_ADD_SAT_EN
      count_q <= over ? '1 : sum[CNT_W-1:0];
`else
      count_q <= sum[CNT_W-1:0];
`endif
    end else begin
      C <= 1'b0;
      if (count_q != '0) begin
        dout    <= 1'b1;
        count_q <= count_q - CNT_W'(1);
        done    <= (count_q == CNT_W'(1));
        // Drain completes only from S_WRITE; entering with count==1 still passes through S_WRITE.
        state   <= (state == S_WRITE && count_q == CNT_W'(1)) ? S_IDLE : S_WRITE;
      end else begin
        dout  <= 1'b0;
        done  <= 1'b0;
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_unary_add_n.sv
// Scoreboard bench for unary_add_n (NUM_IN=4, CNT_W=4): directed scenarios plus random traffic vs. a count-level model.
module tb_unary_add_n;

  localparam int NUM_IN = 4;
  localparam int CNT_W  = 4;
  localparam int MAXV   = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             read_or_write = 1'b0;
  logic [NUM_IN-1:0] din = '0;
  logic             dout, C, ovf, done, busy;
  logic [CNT_W-1:0] count_q;

  unary_add_n #(.NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .read_or_write (read_or_write),
    .din           (din),
    .dout          (dout),
    .C             (C),
    .ovf           (ovf),
    .done          (done),
    .busy          (busy),
    .count_q       (count_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit dout, c, ovf, done, busy;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  // Reference model state: plain integers.
  int  m_cnt = 0;
  bit  m_dout = 0, m_c = 0, m_ovf = 0, m_done = 0, m_busy = 0;

  task automatic chk(input string name, input int cyc, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  // Monitor: the DUT presents a full output set every clock edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dout",    e.cyc, int'(dout),    int'(e.dout));
      chk("C",       e.cyc, int'(C),       int'(e.c));
      chk("ovf",     e.cyc, int'(ovf),     int'(e.ovf));
      chk("done",    e.cyc, int'(done),    int'(e.done));
      chk("busy",    e.cyc, int'(busy),    int'(e.busy));
      chk("count_q", e.cyc, int'(count_q), e.cnt);
    end
  end

  task automatic step(input bit r, input bit e, input bit rw, input logic [NUM_IN-1:0] d);
    exp_t x;
    int   sum;
    @(negedge clk);
    rst = r; en = e; read_or_write = rw; din = d;
    if (r) begin
      m_cnt = 0; m_dout = 0; m_c = 0; m_ovf = 0; m_done = 0; m_busy = 0;
    end else if (!e) begin
      m_done = 0;
    end else if (!rw) begin
      sum = m_cnt + $countones(d);
      m_c = (sum > MAXV);
      m_ovf = m_ovf | m_c;
`ifdef UNARY_ADD_SAT_EN
      m_cnt = (sum > MAXV) ? MAXV : sum;
`else
      m_cnt = sum % (MAXV + 1);
`endif
      m_dout = 0; m_done = 0; m_busy = 0;
    end else begin
      m_c = 0;
      if (m_cnt > 0) begin
        m_dout = 1;
        m_done = (m_cnt == 1);
        m_busy = !(m_busy && m_cnt == 1);
        m_cnt  = m_cnt - 1;
      end else begin
        m_dout = 0; m_done = 0; m_busy = 0;
      end
    end
    x.cyc = cyc_no; x.dout = m_dout; x.c = m_c; x.ovf = m_ovf;
    x.done = m_done; x.busy = m_busy; x.cnt = m_cnt;
    exp_q.push_back(x);
    cyc_no++;
  endtask

  task automatic reads(input int n, input logic [NUM_IN-1:0] d);
    for (int i = 0; i < n; i++) step(0, 1, 0, d);
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, '0);
  endtask

  initial begin
    int wait_cyc;
    // 1: reset
    step(1, 1, 0, '0); step(1, 1, 0, '0);
    // 2: 3 x 1011 -> 9, drain fully plus idle writes
    reads(3, 4'b1011); writes(12);
    // 3: 14 then overflow, then a zero read
    step(1, 1, 0, '0); reads(3, 4'b1111); reads(1, 4'b0011);
    reads(1, 4'b0011); reads(1, 4'b0000);
    // 4: count 5, drain 2, freeze 3, resume
    step(1, 1, 0, '0); reads(1, 4'b1111); reads(1, 4'b0001); writes(2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4'b1111);
    writes(5);
    // 5: count 6, drain 2, reset mid-drain
    step(1, 1, 0, '0); reads(1, 4'b1111); reads(1, 4'b0011); writes(2);
    step(1, 1, 1, '0); writes(2);
    // 6: count 5, drain 2, refill with 1111, drain to done
    step(1, 1, 0, '0); reads(1, 4'b1111); reads(1, 4'b1000); writes(2);
    reads(1, 4'b1111); writes(9);
    // count==1 entering write from read
    step(1, 1, 0, '0); reads(1, 4'b0100); writes(3);
    // random traffic with phase runs
    for (int blk = 0; blk < 60; blk++) begin
      bit rw;
      int len;
      rw  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8), rw, 4'($urandom));
    end
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
